// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Round-robin two-master arbiter and issue/wait/ack sequencer
//               in front of the shared synchronous data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_input_data,
    output logic                  mem_write_enabled,
    input  logic [DATA_WIDTH-1:0] mem_output_data,
    output logic                  busy,
    output logic                  grant
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_ACK   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_arb_phase;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_win_valid;
    logic                  w_winner;

    // The master being acked this cycle is masked so the other side wins the boundary.
    always_comb begin
        w_arb_phase  = (r_state == c_IDLE) || (r_state == c_ACK);
        w_elig0      = m0_req && !((r_state == c_ACK) && (r_grant == 1'b0));
        w_elig1      = m1_req && !((r_state == c_ACK) && (r_grant == 1'b1));
        w_win_valid  = w_arb_phase && (w_elig0 || w_elig1);
        w_winner     = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_winner = ~r_last_grant;
        end else begin
            w_winner = w_elig1;
        end

        w_state_next = r_state;
        case (r_state)
            c_IDLE:  w_state_next = w_win_valid ? c_ISSUE : c_IDLE;
            c_ISSUE: w_state_next = c_WAIT;
            c_WAIT:  w_state_next = c_ACK;
            c_ACK:   w_state_next = w_win_valid ? c_ISSUE : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_win_valid) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
                r_we         <= w_winner ? m1_we    : m0_we;
                r_addr       <= w_winner ? m1_addr  : m0_addr;
                r_wdata      <= w_winner ? m1_wdata : m0_wdata;
            end
            // Synchronous memory: read data is valid during WAIT.
            if ((r_state == c_WAIT) && !r_we) begin
                r_rdata <= mem_output_data;
            end
        end
    end

    assign mem_address       = r_addr;
    assign mem_input_data    = r_wdata;
    assign mem_write_enabled = (r_state == c_ISSUE) && r_we;
    assign busy              = (r_state == c_ISSUE) || (r_state == c_WAIT);
    assign grant             = r_grant;
    assign m0_ack            = (r_state == c_ACK) && (r_grant == 1'b0);
    assign m1_ack            = (r_state == c_ACK) && (r_grant == 1'b1);
    assign m0_rdata          = r_rdata;
    assign m1_rdata          = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_arbiter
// Description : Directed self-checking bench for data_memory_arbiter with a
//               behavioural synchronous RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_input_data;
    logic          mem_write_enabled;
    logic [DW-1:0] mem_output_data = '0;
    logic          busy, grant;

    logic          preload_en = 1'b0;
    logic [7:0]    preload_addr = '0;
    logic [DW-1:0] preload_data = '0;
    logic [DW-1:0] ram [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_input_data(mem_input_data),
        .mem_write_enabled(mem_write_enabled), .mem_output_data(mem_output_data),
        .busy(busy), .grant(grant)
    );

    always @(posedge clock) begin
        if (preload_en) ram[preload_addr] <= preload_data;
        else if (mem_write_enabled) ram[mem_address[7:0]] <= mem_input_data;
        mem_output_data <= ram[mem_address[7:0]];
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // Single transaction from one master; cycle 1 is the first edge after req rises.
    task automatic single_txn(input bit master, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int ack_cycle,
                              output int we_count, output int we_cycle,
                              output logic [31:0] we_addr, output logic [31:0] we_data);
        ack_cycle = 0; we_count = 0; we_cycle = 0; we_addr = '0; we_data = '0;
        @(negedge clock);
        if (master) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (mem_write_enabled) begin
                we_count++; we_cycle = i; we_addr = mem_address; we_data = mem_input_data;
            end
            if ((master && m1_ack) || (!master && m0_ack)) begin
                ack_cycle = i;
                break;
            end
        end
        @(negedge clock);
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        int ack_c, we_n, we_c, k, prev, n0, n1;
        logic [31:0] we_a, we_d, ram_before;
        bit who;

        // Reset state and RAM preload
        preload_en = 1'b1; preload_addr = 8'h04; preload_data = 32'hDEADBEEF;
        @(negedge clock);
        preload_en = 1'b0;
        #1;
        check_value("rst_busy", busy, 0);
        check_value("rst_acks", {m1_ack, m0_ack}, 0);
        check_value("rst_we", mem_write_enabled, 0);
        check_value("rst_grant", grant, 0);
        check_value("rst_rdata", m0_rdata, 0);
        check_value("rst_addr", mem_address, 0);
        check_value("rst_wdata", mem_input_data, 0);
        @(negedge clock);
        resetn = 1'b1;

        // m0 read of RAM 0x04
        single_txn(1'b0, 1'b0, 32'h04, 32'h0, ack_c, we_n, we_c, we_a, we_d);
        check_value("rd_ack_lat", ack_c, 3);
        check_value("rd_we_cnt", we_n, 0);
        check_value("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check_value("rd_m1_rdata", m1_rdata, 32'hDEADBEEF);

        // m1 write to 0x08, then m0 reads it back
        single_txn(1'b1, 1'b1, 32'h08, 32'h12345678, ack_c, we_n, we_c, we_a, we_d);
        check_value("wr_we_cnt", we_n, 1);
        check_value("wr_we_addr", we_a, 32'h08);
        check_value("wr_we_data", we_d, 32'h12345678);
        check_value("wr_ack_after_we", ack_c - we_c, 2);
        check_value("wr_grant", grant, 1);
        check_value("wr_rdata_kept", m1_rdata, 32'hDEADBEEF);
        single_txn(1'b0, 1'b0, 32'h08, 32'h0, ack_c, we_n, we_c, we_a, we_d);
        check_value("rdback_lat", ack_c, 3);
        check_value("rdback_data", m0_rdata, 32'h12345678);

        // I/O write at 0x80
        single_txn(1'b0, 1'b1, 32'h80, 32'h000000FF, ack_c, we_n, we_c, we_a, we_d);
        check_value("io_we_cnt", we_n, 1);
        check_value("io_addr_bit7", we_a[7], 1);
        check_value("io_we_addr", we_a, 32'h80);
        check_value("io_ack_after_we", ack_c - we_c, 2);
        check_value("io_ram", ram[8'h80], 32'h000000FF);

        // m0 alone, req held: one IDLE cycle between ack and next ISSUE
        @(negedge clock);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h04;
        k = 0; prev = 0;
        for (int i = 1; i <= 40 && k < 3; i++) begin
            @(posedge clock);
            #1;
            if (k > 0 && i == prev + 1) check_value("solo_idle_busy", busy, 0);
            if (m1_ack) check_value("solo_m1_ack", m1_ack, 0);
            if (m0_ack) begin
                if (k == 0) check_value("solo_first_ack", i, 3);
                else check_value("solo_gap", i - prev, 4);
                prev = i;
                k++;
            end
        end
        @(negedge clock);
        m0_req = 1'b0;
        check_value("solo_count", k, 3);

        // Continuous load with no history after reset
        pulse_reset();
        @(negedge clock);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h04;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h08;
        k = 0; prev = 0; n0 = 0; n1 = 0;
        for (int i = 1; i <= 80 && k < 12; i++) begin
            @(posedge clock);
            #1;
            if (m0_ack && m1_ack) check_value("both_acks", 1, 0);
            if (m0_ack || m1_ack) begin
                who = m1_ack;
                check_value("alt_master", who, k % 2);
                check_value("alt_grant", grant, k % 2);
                check_value("alt_rdata", m0_rdata, who ? 32'h12345678 : 32'hDEADBEEF);
                if (k == 0) check_value("alt_first_ack", i, 3);
                else check_value("alt_gap", i - prev, 3);
                if (who) n1++; else n0++;
                prev = i;
                k++;
            end
        end
        @(negedge clock);
        m0_req = 1'b0; m1_req = 1'b0;
        check_value("alt_n0", n0, 6);
        check_value("alt_n1", n1, 6);

        // Reset asserted during WAIT of an m1 write
        repeat (3) @(negedge clock);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hCAFEF00D;
        @(posedge clock); #1;
        check_value("rw_issue_we", mem_write_enabled, 1);
        @(posedge clock); #1;
        check_value("rw_wait_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        check_value("rw_rst_we", mem_write_enabled, 0);
        check_value("rw_rst_busy", busy, 0);
        check_value("rw_rst_grant", grant, 0);
        @(negedge clock);
        m1_req = 1'b0;
        @(posedge clock); #1;
        check_value("rw_no_ack", {m1_ack, m0_ack}, 0);
        @(negedge clock);
        resetn = 1'b1;

        // Reset asserted during ISSUE drops the write strobe before the RAM samples it
        ram_before = ram[8'h20];
        @(negedge clock);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h0BADF00D;
        @(posedge clock); #1;
        check_value("ri_issue_we", mem_write_enabled, 1);
        #2 resetn = 1'b0;
        #1;
        check_value("ri_rst_we", mem_write_enabled, 0);
        @(negedge clock);
        m1_req = 1'b0;
        @(posedge clock); #1;
        check_value("ri_ram_kept", ram[8'h20], ram_before);
        check_value("ri_no_ack", {m1_ack, m0_ack}, 0);
        @(negedge clock);
        resetn = 1'b1;

        // First tie after reset goes to m0
        @(negedge clock);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h04;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h08;
        ack_c = 0; who = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (m0_ack || m1_ack) begin
                ack_c = i;
                who = m1_ack;
                break;
            end
        end
        @(negedge clock);
        m0_req = 1'b0; m1_req = 1'b0;
        check_value("tie_lat", ack_c, 3);
        check_value("tie_master", who, 0);

        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-master arbiter and sequencer for the shared data memory (RAM below address bit 7, memory-mapped I/O at or above it). It sits between the memory and two requesters: master 0 is the CPU data path and master 1 is the auxiliary loader/debug port. It grants masters round-robin, registers the granted command, and drives the memory through a fixed three-cycle issue/wait/acknowledge sequence. It returns captured read data with a one-cycle acknowledge pulse.

## Interface
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, memory data width

- clock  in  1  memory clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1 each  request; held high until the matching ack
- m0_we, m1_we  in  1 each  1 = write, 0 = read; stable while req high
- m0_addr, m1_addr  in  ADDR_WIDTH each  byte address; stable while req high
- m0_wdata, m1_wdata  in  DATA_WIDTH each  write data; stable while req high
- m0_ack, m1_ack  out  1 each  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_WIDTH each  shared captured read register, same value on both; valid in ack cycle and held until next capture
- mem_address  out  ADDR_WIDTH  to memory address
- mem_input_data  out  DATA_WIDTH  to memory write data
- mem_write_enabled  out  1  to memory write enable
- mem_output_data  in  DATA_WIDTH  from memory, synchronous read, valid one cycle after address
- busy  out  1  high in ISSUE and WAIT
- grant  out  1  index of current/last granted master

## Operation
- State machine: IDLE, ISSUE, WAIT, ACK.
- Arbitration is evaluated in IDLE and ACK only.
  - Eligible requests are the req lines, with the master being acked in that cycle masked off.
  - One eligible master: it wins.
  - Both eligible: the master not equal to last_grant wins.
  - No eligible master: go to or stay in IDLE.
  - A winner moves the FSM to ISSUE.
- On the winning edge:
  - latch the winner's addr, we and wdata into command registers;
  - set grant and last_grant to the winner.
- ISSUE:
  - mem_address = latched addr;
  - mem_input_data = latched wdata;
  - mem_write_enabled = latched we.
  - Next state: WAIT.
- WAIT:
  - mem_address and mem_input_data held;
  - mem_write_enabled = 0.
  - At the end of WAIT, capture mem_output_data into the rdata register on reads only; writes leave rdata unchanged.
  - Next state: ACK.
- ACK:
  - m{grant}_ack = 1 for exactly one cycle;
  - mem_write_enabled = 0.
  - Arbitrate as above, so back-to-back grants are possible.
- A master keeping req high after its ack issues a new transaction. Because it is masked in the ACK cycle, the other requester gets priority at that boundary.
- Address bit 7 (RAM vs I/O) is passed through untouched; decode stays in the memory.
- Reset values:
  - state IDLE; busy 0; both acks 0; mem_write_enabled 0;
  - grant 0; last_grant 1, so master 0 wins the first tie;
  - rdata 0; mem_address 0; mem_input_data 0.
- Reset mid-transaction:
  - asynchronous clear to the values above, immediately, including dropping an in-flight mem_write_enabled;
  - no ack for the aborted transaction.
- A req dropped before its ack (protocol violation) does not abort the transaction; the ack still pulses.

## Timing
- Transaction latency: grant edge at cycle N, ISSUE in N+1, WAIT in N+2, ACK in N+3.
- Minimum spacing between acks under continuous load: 3 cycles.
- Request first seen high in IDLE at cycle N: ISSUE in N+1.
- mem_write_enabled is high for exactly one cycle per write (ISSUE only); never high in IDLE, WAIT or ACK.
- All outputs are registered or decoded from the registered state; no combinational path from any req to mem_* or ack.
- Simultaneous requests with no prior history: master 0 first, master 1 at the next ACK.

## Test plan
- Reset, then m0 reads addr 0x04 from RAM preloaded with 0xDEADBEEF -> mem_write_enabled never high; m0_ack pulses 3 cycles after grant; m0_rdata = 0xDEADBEEF.
- m1 writes 0x12345678 to 0x08 -> mem_write_enabled high exactly one cycle with mem_address 0x08; m1_ack 2 cycles later; a following m0 read of 0x08 returns 0x12345678.
- Both masters hold req continuously for 12 transactions -> grants alternate 0,1,0,1…, acks every 3 cycles, 6 acks each.
- m0 requests alone repeatedly while m1 idle -> m0 granted back-to-back, one IDLE cycle between ack and the next ISSUE (masking).
- Write to I/O address 0x80 with value 0x0000_00FF -> mem_address bit 7 set, write pulse one cycle, ack 2 cycles later.
- resetn low during WAIT of a write -> mem_write_enabled 0 and state IDLE immediately, no ack, grant 0; after release the first tie goes to m0.
